// File: rtl/parking_time_tracker.sv
// Parking slot occupancy table with per-slot entry timestamps and a free-running
// time base; a small FSM serialises entry/exit requests and reports ack/err pulses.
module parking_time_tracker #(
  parameter int NUM_SLOTS = 8,
  parameter int TICK_DIV  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           entry_req,
  input  logic                           exit_req,
  input  logic [$clog2(NUM_SLOTS)-1:0]   slot_id,
  output logic                           req_ack,
  output logic                           req_err,
  output logic [7:0]                     time_in,
  output logic [7:0]                     time_out,
  output logic                           times_valid,
  output logic [NUM_SLOTS-1:0]           occupied,
  output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
  output logic [7:0]                     current_time
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int PRE_W  = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    LEAVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r, state_nx_s;
  logic [PRE_W-1:0]     pre_r;
  logic [7:0]           time_r;
  logic [SLOT_W-1:0]    slot_r;
  logic [NUM_SLOTS-1:0] occupied_r;
  logic [7:0]           ts_r [NUM_SLOTS];
  logic [7:0]           time_in_r, time_out_r;
  logic                 ack_r, err_r, tv_r;

  logic slot_ok_s, slot_busy_s, slot_load_s, set_s, clr_s;
  logic ack_nx_s, err_nx_s, tv_nx_s;

  function automatic logic [CNT_W-1:0] count_free(input logic [NUM_SLOTS-1:0] occ);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + CNT_W'(~occ[i]);
    end
    return n;
  endfunction

  // Out-of-range slot numbers (non power-of-two NUM_SLOTS) are treated as free and unusable.
  assign slot_ok_s   = (32'(slot_r) < NUM_SLOTS);
  assign slot_busy_s = slot_ok_s && occupied_r[slot_r];

  // Time base: prescaler wraps every TICK_DIV cycles and bumps current_time mod 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r  <= '0;
      time_r <= 8'd0;
    end else if (pre_r == PRE_W'(TICK_DIV - 1)) begin
      pre_r  <= '0;
      time_r <= time_r + 8'd1;
    end else begin
      pre_r  <= pre_r + PRE_W'(1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state and action decode; entry takes priority over exit in IDLE.
  always_comb begin
    state_nx_s  = state_r;
    slot_load_s = 1'b0;
    set_s       = 1'b0;
    clr_s       = 1'b0;
    ack_nx_s    = 1'b0;
    err_nx_s    = 1'b0;
    tv_nx_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_req) begin
          state_nx_s  = ENTER;
          slot_load_s = 1'b1;
        end else if (exit_req) begin
          state_nx_s  = LEAVE;
          slot_load_s = 1'b1;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      ENTER: begin
        state_nx_s = DONE;
        if (slot_ok_s && !slot_busy_s) begin
          set_s    = 1'b1;
          ack_nx_s = 1'b1;
        end else begin
          err_nx_s = 1'b1;
        end
      end
      LEAVE: begin
        state_nx_s = DONE;
        if (slot_busy_s) begin
          clr_s    = 1'b1;
          ack_nx_s = 1'b1;
          tv_nx_s  = 1'b1;
        end else begin
          err_nx_s = 1'b1;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Slot table, captured timestamps and status pulses; time_r is the pre-edge value here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r     <= '0;
      occupied_r <= '0;
      time_in_r  <= 8'd0;
      time_out_r <= 8'd0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      tv_r       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) ts_r[i] <= 8'd0;
    end else begin
      ack_r <= ack_nx_s;
      err_r <= err_nx_s;
      tv_r  <= tv_nx_s;
      if (slot_load_s) slot_r <= slot_id;
      if (set_s) begin
        occupied_r[slot_r] <= 1'b1;
        ts_r[slot_r]       <= time_r;
      end
      if (clr_s) begin
        occupied_r[slot_r] <= 1'b0;
        time_in_r          <= ts_r[slot_r];
        time_out_r         <= time_r;
      end
    end
  end

  assign req_ack      = ack_r;
  assign req_err      = err_r;
  assign times_valid  = tv_r;
  assign time_in      = time_in_r;
  assign time_out     = time_out_r;
  assign occupied     = occupied_r;
  assign current_time = time_r;
  assign free_count   = count_free(occupied_r);

endmodule
